// File: rtl/ah4_responder_if.sv
// START/KEY link between an AH-4 style controller (master) and the tuner-side responder (slave).
interface ah4_responder_if;
    logic start;
    logic rf_detect;
    logic tune_fail_in;
    logic key;
    logic bypass;
    logic tuning;
    logic tune_done;
    logic tune_fail;

    modport master (
        output start, rf_detect, tune_fail_in,
        input  key, bypass, tuning, tune_done, tune_fail
    );

    modport slave (
        input  start, rf_detect, tune_fail_in,
        output key, bypass, tuning, tune_done, tune_fail
    );
endinterface

// File: rtl/ah4_responder.sv
// AH-4 tuner-side responder: classifies START pulses as bypass or tune requests and drives KEY.
// All state advances only on millisecond strobes; START and rf_detect are synchronized first.
module ah4_responder #(
    parameter logic [11:0] RESP_MS    = 12'd100,
    parameter logic [11:0] BYP_MIN_MS = 12'd20,
    parameter logic [11:0] RF_WAIT_MS = 12'd3000,
    parameter logic [11:0] TUNE_MS    = 12'd1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            millisec_pulse,
    ah4_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_MEASURE = 3'd2,
        ST_BUSY    = 3'd3,
        ST_WAIT_RF = 3'd4,
        ST_TUNE    = 3'd5,
        ST_FAIL    = 3'd6
    } state_t;

    logic [1:0]  start_sync_q;
    logic [1:0]  rf_sync_q;
    logic        start_s;
    logic        rf_s;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        key_q, key_d;
    logic        bypass_q, bypass_d;
    logic        tuning_q, tuning_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;

    // Two-flop synchronizers; START resets to the asserted level so ARM needs a genuine high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= 2'b00;
            rf_sync_q    <= 2'b00;
        end else begin
            start_sync_q <= {start_sync_q[0], bus.start};
            rf_sync_q    <= {rf_sync_q[0], bus.rf_detect};
        end
    end

    assign start_s = start_sync_q[1];
    assign rf_s    = rf_sync_q[1];

    // State, counter and output registers, advanced once per millisecond strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARM;
            cnt_q    <= 12'd0;
            key_q    <= 1'b1;
            bypass_q <= 1'b0;
            tuning_q <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else if (millisec_pulse) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            bypass_q <= bypass_d;
            tuning_q <= tuning_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    // Next-state and next-output logic; line conditions take precedence over counter expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        bypass_d = bypass_q;
        done_d   = done_q;
        fail_d   = fail_q;
        case (state_q)
            ST_ARM: begin
                key_d = 1'b1;
                if (start_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_IDLE: begin
                if (!start_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = 12'd1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (start_s) begin
                    state_d = ST_IDLE;
                    if (cnt_q >= BYP_MIN_MS) begin
                        bypass_d = 1'b1;
                    end else begin
                        bypass_d = bypass_q;
                    end
                end else if (cnt_q >= RESP_MS) begin
                    // Counter saturated at RESP_MS: this pulse is the tune request.
                    state_d  = ST_BUSY;
                    key_d    = 1'b0;
                    bypass_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_BUSY: begin
                key_d = 1'b0;
                if (start_s) begin
                    state_d = ST_WAIT_RF;
                    cnt_d   = RF_WAIT_MS;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_WAIT_RF: begin
                key_d = 1'b0;
                if (rf_s) begin
                    state_d = ST_TUNE;
                    cnt_d   = TUNE_MS;
                end else if (cnt_q == 12'd0) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            ST_TUNE: begin
                key_d = 1'b0;
                if (!rf_s) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else if (cnt_q == 12'd0) begin
                    if (bus.tune_fail_in) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        // Success completes in one strobe: release KEY and return to IDLE.
                        state_d = ST_IDLE;
                        key_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            ST_FAIL: begin
                if (!start_s) begin
                    state_d = ST_MEASURE;
                    key_d   = 1'b1;
                    cnt_d   = 12'd1;
                    fail_d  = 1'b0;
                end else begin
                    state_d = ST_FAIL;
                    key_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_ARM;
                key_d   = 1'b1;
            end
        endcase
    end

    // Registered tuning flag follows the state being entered.
    always_comb begin
        tuning_d = 1'b0;
        case (state_d)
            ST_BUSY, ST_WAIT_RF, ST_TUNE: tuning_d = 1'b1;
            default:                      tuning_d = 1'b0;
        endcase
    end

    assign bus.key       = key_q;
    assign bus.bypass    = bypass_q;
    assign bus.tuning    = tuning_q;
    assign bus.tune_done = done_q;
    assign bus.tune_fail = fail_q;

endmodule
